// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   div_state_e  : FSM states (IDLE, RUN, FIX, DONE)
//   DEFAULT_XLEN : default datapath width
//   WORD_W       : word-mode operand width (DIVW/REMW family)
//   WORD_MIN     : most-negative 32-bit value
//   MAX_W        : widest datapath the negate helper supports
//   twos_neg()   : two's complement negate at MAX_W bits
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_e;

  localparam int DEFAULT_XLEN = 64;
  localparam int WORD_W       = 32;
  localparam logic [WORD_W-1:0] WORD_MIN = 32'h8000_0000;
  localparam int MAX_W        = 128;

  // Callers zero-extend into MAX_W and keep the low bits of the result.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] v);
    return (~v) + {{(MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   i_rem  : partial remainder (always < i_div on entry)
//   i_bit  : next dividend bit shifted in
//   i_div  : divisor magnitude
//   o_rem  : new partial remainder
//   o_qbit : quotient bit produced by this step
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_bit,
  input  logic [W-1:0] i_div,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_part;
  logic [W:0] w_diff;

  // {rem,bit} < 2*div, so a W+1 bit subtraction sets bit W exactly on borrow.
  assign w_part = {i_rem, i_bit};
  assign w_diff = w_part - {1'b0, i_div};
  assign o_qbit = ~w_diff[W];
  assign o_rem  = o_qbit ? w_diff[W-1:0] : w_part[W-1:0];

endmodule

// File: rtl/div_unit.sv
// Parametrised iterative restoring divider (signed/unsigned, RV64 word mode).
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready high only in IDLE)
//   in_a, in_b            : dividend, divisor
//   div_signed, div_word  : signed op; 32-bit word op with sign-extended result
//   flush                 : kill in-flight op, return to IDLE
//   out_valid / out_ready : result handshake
//   quotient, remainder   : registered results, stable while out_valid
//   busy                  : state != IDLE
// Optional build macro DIV_SPECIAL_BYPASS_EN: divide-by-zero and signed
// overflow load their results at accept and go straight to DONE.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            div_signed,
  input  logic            div_word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            busy
);

  // Shift that moves bit 31 to the MSB; word-mode extension uses it.
  localparam int SH = (XLEN > WORD_W) ? XLEN - WORD_W : 0;

  function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
    logic [MAX_W-1:0] t;
    t = twos_neg(MAX_W'(v));
    return t[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] f_sext_w(input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] t;
    t = $signed(v << SH);
    return $unsigned(t >>> SH);
  endfunction

  function automatic logic [XLEN-1:0] f_zext_w(input logic [XLEN-1:0] v);
    return (v << SH) >> SH;
  endfunction

  // Sign correction, special-case override, then word-mode extension.
  function automatic logic [2*XLEN-1:0] f_result(
    input logic [XLEN-1:0] q_mag,
    input logic [XLEN-1:0] r_mag,
    input logic [XLEN-1:0] a_eff,
    input logic            nq,
    input logic            nr,
    input logic            dz,
    input logic            ovf,
    input logic            word
  );
    logic [XLEN-1:0] q;
    logic [XLEN-1:0] r;
    q = nq ? f_neg(q_mag) : q_mag;
    r = nr ? f_neg(r_mag) : r_mag;
    if (dz) begin
      q = '1;
      r = a_eff;
    end else if (ovf) begin
      q = a_eff;
      r = '0;
    end
    if (word) begin
      q = f_sext_w(q);
      r = f_sext_w(r);
    end
    return {q, r};
  endfunction

  div_state_e      r_state;
  div_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_div;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_q;
  logic [XLEN-1:0] r_a_eff;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_dz;
  logic            r_ovf;
  logic            r_word;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_remd;

  logic            w_accept;
  logic [XLEN-1:0] w_a_eff;
  logic [XLEN-1:0] w_b_eff;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic [XLEN-1:0] w_min;
  logic            w_dz;
  logic            w_ovf;
  logic [XLEN-1:0] w_dvd_init;
  logic            w_last;
  logic [XLEN-1:0] w_step_rem;
  logic            w_qbit;
  logic [2*XLEN-1:0] w_fix;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quot;
  assign remainder = r_remd;

  assign w_accept = in_valid & in_ready & ~flush;

  assign w_a_eff  = div_word ? (div_signed ? f_sext_w(in_a) : f_zext_w(in_a)) : in_a;
  assign w_b_eff  = div_word ? (div_signed ? f_sext_w(in_b) : f_zext_w(in_b)) : in_b;
  assign w_sign_a = div_signed & w_a_eff[XLEN-1];
  assign w_sign_b = div_signed & w_b_eff[XLEN-1];
  assign w_abs_a  = w_sign_a ? f_neg(w_a_eff) : w_a_eff;
  assign w_abs_b  = w_sign_b ? f_neg(w_b_eff) : w_b_eff;
  assign w_min    = div_word ? f_sext_w(XLEN'(WORD_MIN)) : {1'b1, {(XLEN-1){1'b0}}};
  assign w_dz     = (w_b_eff == '0);
  assign w_ovf    = div_signed & (w_a_eff == w_min) & (w_b_eff == '1);
  // Word mode iterates only 32 steps, so park the dividend's bit 31 at the MSB.
  assign w_dvd_init = div_word ? (w_abs_a << SH) : w_abs_a;

  assign w_last = (r_cnt == (r_word ? CNT_W'(WORD_W - 1) : CNT_W'(XLEN - 1)));
  assign w_fix  = f_result(r_q, r_rem, r_a_eff, r_neg_q, r_neg_r, r_dz, r_ovf, r_word);

`ifdef DIV_SPECIAL_BYPASS_EN
  logic              w_special;
  logic [2*XLEN-1:0] w_byp;
  assign w_special = w_dz | w_ovf;
  assign w_byp = f_result('0, '0, w_a_eff, w_sign_a ^ w_sign_b, w_sign_a,
                          w_dz, w_ovf, div_word);
`endif

  div_step #(.W(XLEN)) u_step (
    .i_rem (r_rem),
    .i_bit (r_dvd[XLEN-1]),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_qbit(w_qbit)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_SPECIAL_BYPASS_EN
          w_state_nxt = w_special ? DONE : RUN;
`else
          w_state_nxt = RUN;
`endif
        end
      end
      RUN:  if (w_last) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_a_eff <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_ovf   <= 1'b0;
      r_word  <= 1'b0;
      r_quot  <= '0;
      r_remd  <= '0;
    end else begin
      if (r_state == RUN && !flush) r_cnt <= r_cnt + CNT_W'(1);
      else                          r_cnt <= '0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd   <= w_dvd_init;
            r_div   <= w_abs_b;
            r_rem   <= '0;
            r_q     <= '0;
            r_a_eff <= w_a_eff;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            r_word  <= div_word;
`ifdef DIV_SPECIAL_BYPASS_EN
            if (w_special) begin
              r_quot <= w_byp[2*XLEN-1:XLEN];
              r_remd <= w_byp[XLEN-1:0];
            end
`endif
          end
        end
        RUN: begin
          r_rem <= w_step_rem;
          r_q   <= {r_q[XLEN-2:0], w_qbit};
          r_dvd <= {r_dvd[XLEN-2:0], 1'b0};
        end
        FIX: begin
          if (!flush) begin
            r_quot <= w_fix[2*XLEN-1:XLEN];
            r_remd <= w_fix[XLEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        div_signed;
  logic        div_word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] quotient;
  logic [63:0] remainder;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Latency counts clock edges with the accept edge as edge 1.
`ifdef DIV_SPECIAL_BYPASS_EN
  localparam int SP_LAT   = 1;
  localparam int SP_LAT_W = 1;
`else
  localparam int SP_LAT   = 66;
  localparam int SP_LAT_W = 34;
`endif

  always #5 clk = ~clk;

  div_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .div_signed(div_signed),
    .div_word  (div_word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic w, input logic [63:0] eq,
                        input logic [63:0] er, input int elat, input int hold);
    int   lat;
    logic rdy_bad;
    logic hold_bad;
    @(negedge clk);
    check($sformatf("%s_rdy_idle", tag), {63'd0, in_ready}, 64'd1);
    in_a = a; in_b = b; div_signed = s; div_word = w; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = 64'hDEAD_BEEF_0BAD_F00D;
    in_b = 64'h0000_0000_0000_0003;
    div_signed = ~s;
    div_word = ~w;
    lat = 1;
    rdy_bad = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("%s_lat", tag), 64'(lat), 64'(elat));
    check($sformatf("%s_q", tag), quotient, eq);
    check($sformatf("%s_r", tag), remainder, er);
    check($sformatf("%s_rdy_busy", tag), {63'd0, rdy_bad | in_ready}, 64'd0);
    if (hold > 0) begin
      hold_bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== eq || remainder !== er)
          hold_bad = 1'b1;
      end
      check($sformatf("%s_hold", tag), {63'd0, hold_bad}, 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check($sformatf("%s_drain", tag), {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    logic bad;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    div_signed = 1'b0; div_word = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst_q", quotient, 64'd0);
    check("rst_r", remainder, 64'd0);
    check("rst_flags", {60'd0, out_valid, busy, in_ready, 1'b0}, 64'h2);

    run_op("u100_7", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 64'd2, 66, 10);
    run_op("s_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("s_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66, 0);
    run_op("u_big_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0,
           64'h0FFF_FFFF_FFFF_FFFF, 64'd15, 66, 0);
    run_op("u_dz", 64'd5, 64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, SP_LAT, 0);
    run_op("s_dz", 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, SP_LAT, 0);
    run_op("s_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
           64'h8000_0000_0000_0000, 64'd0, SP_LAT, 0);
    run_op("w_ovf", 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
           64'hFFFF_FFFF_8000_0000, 64'd0, SP_LAT_W, 0);
    run_op("w_u", 64'h0000_0001_FFFF_FFFE, 64'd2, 1'b0, 1'b1,
           64'h0000_0000_7FFF_FFFF, 64'd0, 34, 0);
    run_op("w_u_sx", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 34, 0);
    run_op("w_s_m7_2", 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 1'b1, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0);

    // Flush in RUN cycle 20 with a competing request.
    @(negedge clk);
    in_a = 64'd100; in_b = 64'd7; div_signed = 1'b0; div_word = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_a = 64'd9; in_b = 64'd3;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_state", {61'd0, in_ready, busy, out_valid}, 64'h4);
    bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) bad = 1'b1;
    end
    check("flush_quiet", {63'd0, bad}, 64'd0);
    run_op("post_flush", 64'd1000, 64'd10, 1'b0, 1'b0, 64'd100, 64'd0, 66, 0);

    // Reset in the middle of an operation clears the result registers.
    @(negedge clk);
    in_a = 64'd77; in_b = 64'd5; div_signed = 1'b0; div_word = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_q", quotient, 64'd0);
    check("midrst_r", remainder, 64'd0);
    check("midrst_flags", {61'd0, in_ready, busy, out_valid}, 64'h4);
    run_op("post_rst", 64'd77, 64'd5, 1'b0, 1'b0, 64'd15, 64'd2, 66, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
